// File: rtl/serial_addsub.sv
// Purpose : bit-serial add/subtract, one full-adder/subtractor cell plus a carry/borrow flop, LSB first.
// Latency : WIDTH cycles from the accept edge to the done edge; peak issue interval WIDTH+1 cycles.
// Backpr. : start is only accepted while busy=0; start during busy is dropped with no side effect.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start, mode       request strobe; mode 0 = a - b, 1 = a + b (sampled on accept)
//   a, b              WIDTH-bit operands, sampled on accept
//   busy, done        operation in progress; one-cycle pulse when result/flags update
//   result            sum or difference modulo 2^WIDTH
//   cout              carry out (add) or borrow out (subtract) of the MSB
//   overflow, zero    two's-complement signed overflow; result == 0
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    // Reject illegal widths at elaboration rather than producing a broken datapath.
    if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
        $error("serial_addsub: WIDTH must be in the range 2..64");
    end

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Counter value while the MSB pair sits at the bottom of the operand registers.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic             mode_q,   mode_d;
    logic             c_q,      c_d;
    // The result shift register only needs WIDTH-1 bits: the final bit is
    // produced combinationally on the last edge and goes straight into result_q.
    logic [WIDTH-2:0] res_sh_q, res_sh_d;

    // Architectural outputs are held in their own registers so they stay
    // stable while the next operation is being shifted through.
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;
    logic             zero_q,   zero_d;
    logic             done_q,   done_d;

    // ------------------------------------------------------------------
    // The single arithmetic cell
    // ------------------------------------------------------------------
    logic             ai;
    logic             bi;
    logic             sum_bit;
    logic             c_nxt;
    logic [WIDTH-1:0] res_full;

    always_comb begin
        ai      = a_sh_q[0];
        bi      = b_sh_q[0];
        sum_bit = ai ^ bi ^ c_q;
        if (mode_q) begin
            // full adder carry
            c_nxt = (ai & bi) | ((ai ^ bi) & c_q);
        end else begin
            // full subtractor borrow
            c_nxt = (~ai & bi) | (~(ai ^ bi) & c_q);
        end
        // New bit enters from the MSB side, so after WIDTH steps the
        // LSB-first stream lands in natural bit order.
        res_full = {sum_bit, res_sh_q};
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        mode_d   = mode_q;
        c_d      = c_q;
        res_sh_d = res_sh_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    mode_d  = mode;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                end
            end

            ST_RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                c_d      = c_nxt;
                res_sh_d = res_full[WIDTH-1:1];
                cnt_d    = cnt_q + CNT_W'(1);

                if (cnt_q == LAST_BIT) begin
                    state_d  = ST_IDLE;
                    result_d = res_full;
                    cout_d   = c_nxt;
                    // c_q is the carry/borrow into the MSB, c_nxt the one out of it;
                    // their disagreement is signed overflow for both add and subtract.
                    ovf_d    = c_q ^ c_nxt;
                    zero_d   = (res_full == '0);
                    done_d   = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            mode_q   <= 1'b0;
            c_q      <= 1'b0;
            res_sh_q <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            mode_q   <= mode_d;
            c_q      <= c_d;
            res_sh_q <= res_sh_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // busy drops on the same edge that raises done, which is what lets a
    // start held high through the done cycle be accepted on the next edge.
    assign busy     = (state_q == ST_RUN);
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule
